// File: rtl/data_memory_banked.sv
// Byte-addressed data memory with wait states, lane merging, load extension
// and a sequential post-reset clear of the whole array.
module data_memory_banked #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int TEST_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           A,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  output logic [TEST_WIDTH-1:0] test_value
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("data_memory_banked: DATA_WIDTH must be 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("data_memory_banked: WAIT_STATES must be 0..15");
  end

  typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [3:0]    cnt;
  logic          r_we;
  logic          r_uns;
  logic [1:0]    r_size;
  logic [31:0]   r_a;
  logic [31:0]   r_wd;
  logic [31:0]   mem [DEPTH];

  // Operand view: live inputs on the accepting edge, captured copy afterwards
  logic          idle;
  logic          o_we;
  logic [1:0]    o_size;
  logic [31:0]   o_a;
  logic [31:0]   o_wd;
  logic [AW-1:0] o_idx;
  logic          misal;
  logic          oor;
  logic          o_bad;
  logic          go_done;
  logic          wen;
  logic [31:0]   merged;

  assign idle   = (state == IDLE);
  assign o_we   = idle ? we   : r_we;
  assign o_size = idle ? size : r_size;
  assign o_a    = idle ? A    : r_a;
  assign o_wd   = idle ? WD   : r_wd;
  assign o_idx  = o_a[AW+1:2];

  assign misal = (o_size == 2'b01 && o_a[0])
              || (o_size[1] && o_a[1:0] != 2'b00);
  assign oor   = {2'b00, o_a[31:2]} >= 32'(DEPTH);
  assign o_bad = misal || oor;

  assign go_done = (idle && req && WAIT_STATES == 0)
                || (state == WAIT && cnt == 4'd0);
  assign wen = go_done && o_we && !o_bad;

  always_comb begin
    merged = mem[o_idx];
    unique case (1'b1)
      o_size == 2'b00:
        merged[{o_a[1:0], 3'b000} +: 8] = o_wd[7:0];
      o_size == 2'b01:
        merged[{o_a[1], 4'b0000} +: 16] = o_wd[15:0];
      default:
        merged = o_wd;
    endcase
  end

  // Array has no reset: INIT zeroes it one word per cycle
  always_ff @(posedge clk) begin
    if (state == INIT) mem[clr_idx] <= '0;
    else if (wen) mem[o_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_idx <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_a     <= '0;
      r_wd    <= '0;
    end else begin
      ready <= go_done;
      err   <= go_done && o_bad;
      unique case (state)
        INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH - 1)) begin
            clr_idx <= '0;
            state   <= IDLE;
          end
        end
        IDLE: begin
          if (req) begin
            r_we   <= we;
            r_uns  <= uns;
            r_size <= size;
            r_a    <= A;
            r_wd   <= WD;
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  logic [31:0] ld_word;
  logic [31:0] b_sh;
  logic [31:0] h_sh;
  logic [31:0] ld_val;

  assign ld_word = mem[r_a[AW+1:2]];
  assign b_sh    = ld_word >> {r_a[1:0], 3'b000};
  assign h_sh    = ld_word >> {r_a[1], 4'b0000};

  always_comb begin
    ld_val = ld_word;
    unique case (1'b1)
      r_size == 2'b00:
        ld_val = {{24{b_sh[7] & ~r_uns}}, b_sh[7:0]};
      r_size == 2'b01:
        ld_val = {{16{h_sh[15] & ~r_uns}}, h_sh[15:0]};
      default:
        ld_val = ld_word;
    endcase
  end

  assign RD = (state == DONE && ready && !err && !r_we) ? ld_val : '0;
  assign busy = (state != IDLE);
  assign test_value = mem[0][TEST_WIDTH-1:0];

endmodule
